// File: rtl/median_pkg.sv
// Shared types and helpers for the median-filter sequencer: FSM encoding,
// counter sizing and the default drain timeout.
package median_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    FILTER = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } median_state_e;

  localparam int DRAIN_MAX_DEF = 64;

  // Snapshot of sequencer control state for waveform viewing and checker binding.
  typedef struct packed {
    logic [2:0] state;
    logic       pulse;
    logic       timeout;
  } median_dbg_t;

  // One spare bit so a counter can hold the terminal value n itself.
  function automatic int cnt_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/median_pix_counter.sv
// Saturating up-counter with synchronous clear; tc_o flags the terminal value MAX.
module median_pix_counter #(
  parameter int W   = 5,
  parameter int MAX = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != MAX_V)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == MAX_V);

endmodule

// File: rtl/median_seq_ctrl.sv
// Load / filter / drain sequencer for the median-filter datapath.
// Optional MEDIAN_SEQ_CTRL_BORDER_EN adds out_border, tagging edge-of-frame outputs.
module median_seq_ctrl
  import median_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_W      = 256,
  parameter int IMG_H      = 256,
  parameter int DRAIN_MAX  = DRAIN_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  src_valid,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  src_ready,
  input  logic                  snk_ready,
  output logic                  en,
  output logic                  push_pop1,
  output logic                  push_pop2,
  output logic [DATA_WIDTH-1:0] dp_data,
  input  logic                  dp_valid,
  output logic                  out_last,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout
`ifdef MEDIAN_SEQ_CTRL_BORDER_EN
  ,
  output logic                  out_border
`endif
);

  localparam int N  = IMG_W * IMG_H;
  localparam int CW = cnt_width(N);
  localparam int DW = cnt_width(DRAIN_MAX);
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

  localparam logic [2:0] ST_IDLE   = IDLE;
  localparam logic [2:0] ST_LOAD   = LOAD;
  localparam logic [2:0] ST_FILTER = FILTER;
  localparam logic [2:0] ST_DRAIN  = DRAIN;
  localparam logic [2:0] ST_DONE   = DONE;

  logic [2:0]            state_q, state_d;
  logic                  pulse_q, pulse_d;
  logic                  timeout_q, timeout_d;
  logic [DATA_WIDTH-1:0] dp_data_q, dp_data_d;

  logic hs, start_ok, clr, filt_inc, drain_inc;
  logic [CW-1:0] load_cnt, filt_cnt, out_cnt;
  logic [DW-1:0] drain_cnt;
  logic load_tc, filt_tc, out_tc, drain_tc;

  median_dbg_t dbg;
  logic        unused_ok;

  // src_ready drops as soon as the last pixel is in, and abort gates it at once.
  assign src_ready = (state_q == ST_LOAD) && !load_tc && !abort;
  assign hs        = src_valid && src_ready;
  assign start_ok  = (state_q == ST_IDLE) && start && !abort;
  assign clr       = start_ok || abort;
  assign filt_inc  = en && (state_q == ST_FILTER);
  assign drain_inc = (state_q == ST_DRAIN);

  median_pix_counter #(.W(CW), .MAX(N)) u_load_cnt (
    .clk(clk), .reset(reset), .clr_i(clr), .inc_i(hs),
    .cnt_o(load_cnt), .tc_o(load_tc)
  );

  median_pix_counter #(.W(CW), .MAX(N)) u_filt_cnt (
    .clk(clk), .reset(reset), .clr_i(clr), .inc_i(filt_inc),
    .cnt_o(filt_cnt), .tc_o(filt_tc)
  );

  median_pix_counter #(.W(CW), .MAX(N)) u_out_cnt (
    .clk(clk), .reset(reset), .clr_i(clr), .inc_i(dp_valid),
    .cnt_o(out_cnt), .tc_o(out_tc)
  );

  median_pix_counter #(.W(DW), .MAX(DRAIN_MAX)) u_drain_cnt (
    .clk(clk), .reset(reset), .clr_i(clr), .inc_i(drain_inc),
    .cnt_o(drain_cnt), .tc_o(drain_tc)
  );

  always_comb begin
    en        = 1'b0;
    push_pop1 = 1'b0;
    push_pop2 = 1'b0;
    if (!abort) begin
      case (state_q)
        ST_LOAD: begin
          en        = pulse_q;
          push_pop1 = pulse_q;
        end
        ST_FILTER: begin
          en        = snk_ready && !filt_tc;
          push_pop2 = 1'b1;
        end
        ST_DRAIN: en = snk_ready;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    timeout_d = timeout_q;
    case (state_q)
      ST_IDLE: begin
        if (start_ok) begin
          state_d   = ST_LOAD;
          timeout_d = 1'b0;
        end
      end
      ST_LOAD:   if (load_tc) state_d = ST_FILTER;
      ST_FILTER: if (filt_inc && (filt_cnt == LAST_IDX)) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // A frame that completes on the same cycle the budget runs out is a success.
        if (out_tc) begin
          state_d = ST_DONE;
        end else if (drain_tc) begin
          state_d   = ST_DONE;
          timeout_d = 1'b1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      timeout_d = timeout_q;
    end
  end

  assign pulse_d   = hs;
  assign dp_data_d = hs ? src_data : dp_data_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      pulse_q   <= 1'b0;
      timeout_q <= 1'b0;
      dp_data_q <= '0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      timeout_q <= timeout_d;
      dp_data_q <= dp_data_d;
    end
  end

  assign dp_data  = dp_data_q;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE) && !abort;
  assign timeout  = timeout_q;
  assign out_last = dp_valid && (out_cnt == LAST_IDX);

  assign dbg       = '{state: state_q, pulse: pulse_q, timeout: timeout_q};
  assign unused_ok = ^{dbg, load_cnt, drain_cnt};

`ifdef MEDIAN_SEQ_CTRL_BORDER_EN
  localparam int RW  = cnt_width(IMG_H);
  localparam int CLW = cnt_width(IMG_W);

  logic [RW-1:0]  row_q, row_d;
  logic [CLW-1:0] col_q, col_d;

  // Raster position of the next output pixel; wraps at the end of each frame.
  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr) begin
      row_d = '0;
      col_d = '0;
    end else if (dp_valid) begin
      if (col_q == CLW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CLW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign out_border = dp_valid && ((row_q == '0) || (row_q == RW'(IMG_H - 1)) ||
                                   (col_q == '0) || (col_q == CLW'(IMG_W - 1)));
`endif

endmodule

// File: doc/median_seq_ctrl.md
Name: median_seq_ctrl

Overview:
- Sequencer for the median-filter `datapath` block.
- Drives `en`, `push_pop1` and `push_pop2` so a frame runs in three phases: load the frame into the line FIFOs, stream the filter pass, then drain until every filtered pixel has been seen on the datapath's `Valid_OUT`.
- Sits between the pixel source / result sink handshakes and the datapath, and replaces hard-coded phase timing with counters and a state machine.

Parameters:
- DATA_WIDTH, 8, pixel width; used only by the pass-through of source data to the datapath.
- IMG_W, 256, pixels per row.
- IMG_H, 256, rows per frame.
- DRAIN_MAX, 64, maximum cycles to wait in DRAIN for outstanding `Valid_OUT` before flagging a timeout.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- abort  in  1  synchronous abort; returns the block to IDLE.
- src_valid  in  1  source pixel valid.
- src_data  in  DATA_WIDTH  source pixel.
- src_ready  out  1  block accepts a source pixel.
- snk_ready  in  1  result sink can accept a pixel.
- en  out  1  datapath enable.
- push_pop1  out  1  datapath load-phase strobe.
- push_pop2  out  1  datapath filter-phase strobe.
- dp_data  out  DATA_WIDTH  registered copy of src_data, feeding datapath DATA_IN.
- dp_valid  in  1  datapath Valid_OUT.
- out_last  out  1  asserted with the final dp_valid of the frame.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at frame completion.
- timeout  out  1  sticky error: DRAIN expired; cleared by start.

Behaviour:
- Reset (async, active-low): state=IDLE; src_ready, en, push_pop1, push_pop2, out_last, busy, done, timeout=0; dp_data=0; all counters=0.
- N = IMG_W*IMG_H. Counters are $clog2(N)+1 bits wide and never wrap mid-frame.
- IDLE:
  - all strobes low.
  - start=1 -> LOAD; load_cnt=0, out_cnt=0, timeout=0.
- LOAD:
  - src_ready=1.
  - Each cycle with src_valid&src_ready: dp_data<=src_data, and next cycle en=1, push_pop1=1 for exactly one cycle; load_cnt++.
  - Cycles without the handshake: en=0, push_pop1=0.
  - Once the N-th pixel is accepted: src_ready drops that same cycle, and the state moves to FILTER on the following cycle.
- FILTER:
  - push_pop2=1; en=snk_ready, so a stalled sink freezes the datapath.
  - filt_cnt increments on en; after N enabled cycles -> DRAIN.
- DRAIN:
  - en=1 only while snk_ready=1; push_pop2=0; drain_cnt increments every cycle.
  - out_cnt==N -> DONE.
  - drain_cnt==DRAIN_MAX first -> timeout=1, then DONE.
- out_cnt (all phases):
  - increments on each dp_valid.
  - out_last=1 combinationally when dp_valid and out_cnt==N-1.
  - dp_valid beyond N is ignored, and out_cnt saturates at N.
- DONE: done=1 for one cycle -> IDLE.
- start outside IDLE is ignored.
- abort in any non-IDLE state -> IDLE next cycle: strobes deassert immediately (combinational gating), counters clear, done is not pulsed. abort and start together in IDLE: abort wins, so the block stays in IDLE.
- Reset asserted mid-frame: immediate return to the reset values, regardless of state.
- Strobe latency: one cycle from the source handshake to the en/push_pop1 pulse; dp_data is valid in the same cycle as that pulse.

Optional Feature:
- Macro: MEDIAN_SEQ_CTRL_BORDER_EN.
- Defined:
  - Adds output `out_border` (1 bit) plus output row/col counters driven by dp_valid.
  - out_border=1 with dp_valid when the output pixel lies in row 0, row IMG_H-1, column 0 or column IMG_W-1.
  - The row/col counters wrap per frame and clear on start or abort.
- Undefined: no port and no counters; all other behaviour identical.

Decomposition:
- Package median_pkg holds:
  - state enum {IDLE, LOAD, FILTER, DRAIN, DONE} (3-bit encoding);
  - function to compute the counter width;
  - DRAIN_MAX default.
- One sub-module, median_pix_counter: a parameterised saturating counter with clear, increment and terminal-count outputs, instantiated for the load, filter, output and drain counters.
- The FSM and strobe generation stay in the top module.

Test Plan (IMG_W=4, IMG_H=4, N=16, DRAIN_MAX=8):
- Reset then start, 16 back-to-back src_valid -> exactly 16 one-cycle push_pop1 pulses; src_ready low after the 16th accept; FILTER entered one cycle later.
- FILTER with snk_ready toggling 1,0,1,0 -> en follows snk_ready; push_pop2 stays high; FILTER exits after exactly 16 enabled cycles.
- Model drives 16 dp_valid pulses -> out_last with the 16th; done pulses once; busy falls; an extra 17th dp_valid leaves out_cnt at 16.
- Only 10 dp_valid pulses in DRAIN -> timeout=1 after 8 DRAIN cycles; done pulses; next start clears timeout.
- abort at load_cnt=7 -> IDLE next cycle with all strobes 0 and no done; a new start reloads a full 16 pixels. Also check start+abort in IDLE stays IDLE.
- reset asserted during FILTER -> outputs at reset values asynchronously. With MEDIAN_SEQ_CTRL_BORDER_EN, a full frame gives out_border on 12 of 16 outputs, interior outputs 5, 6, 9 and 10 low.
